// File: rtl/logic_gate_sequencer.sv
// logic_gate_sequencer
//
// Stimulus and checking controller for the logic primitive library (AND, NAND, OR, NOR,
// XOR, XNOR, INV). It sweeps every input vector onto the gate under test. Each vector is
// held for SETTLE cycles so the gate output can settle. The thresholded output is then
// sampled and compared with the truth table. The run reports a saturating mismatch count,
// the first failing vector and a pass flag.
//
// Parameters:
//   N_IN    number of gate inputs driven (1..4)
//   SETTLE  cycles a vector is held before it is sampled (>= 1)
//   CNT_W   width of the mismatch counter
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset; aborts any run, clears every output
//   start       run request, honoured only in IDLE
//   func        gate under test: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 INV, 7 reserved
//   sample_in   thresholded gate output
//   drive       stimulus vector to the gate inputs (bit 0 = input a)
//   busy        high from start acceptance until the cycle before done
//   done        one-cycle pulse at the end of a run
//   pass        last run finished with zero mismatches
//   err_count   mismatches in the last or current run, saturating
//   fail_vec    first vector that mismatched
//   fail_valid  fail_vec holds a captured vector

module logic_gate_sequencer #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic             sample_in,
  output logic [N_IN-1:0]  drive,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_valid
);

  // Settle counter counts SETTLE-1 down to 0, giving a dwell of exactly SETTLE cycles.
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE - 1);

  localparam logic [2:0] FuncAnd  = 3'd0;
  localparam logic [2:0] FuncNand = 3'd1;
  localparam logic [2:0] FuncOr   = 3'd2;
  localparam logic [2:0] FuncNor  = 3'd3;
  localparam logic [2:0] FuncXor  = 3'd4;
  localparam logic [2:0] FuncXnor = 3'd5;
  localparam logic [2:0] FuncInv  = 3'd6;
  localparam logic [2:0] FuncRsvd = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e          state_q;
  logic [2:0]      func_q;
  logic [CntW-1:0] cnt_q;

  logic expected;
  logic mismatch;

  // Truth table of the latched gate for the vector currently on drive. The vector
  // register is drive itself, so no separate copy is kept.
  always_comb begin
    expected = 1'b0;
    case (func_q)
      FuncAnd:  expected = &drive;
      FuncNand: expected = ~(&drive);
      FuncOr:   expected = |drive;
      FuncNor:  expected = ~(|drive);
      FuncXor:  expected = ^drive;
      FuncXnor: expected = ~(^drive);
      FuncInv:  expected = ~drive[0];  // upper bits are swept but do not matter
      default:  expected = 1'b0;
    endcase
  end

  assign mismatch = (sample_in != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      func_q     <= 3'd0;
      cnt_q      <= '0;
      drive      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            // func is latched in both cases so DONE can tell a reserved request apart.
            func_q     <= func;
            err_count  <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            if (func != FuncRsvd) begin
              drive    <= '0;
              fail_vec <= '0;
              cnt_q    <= CntMax;
              busy     <= 1'b1;
              state_q  <= StSettle;
            end else begin
              state_q  <= StDone;
            end
          end
        end

        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StSample: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (!fail_valid) begin
              fail_vec   <= drive;
              fail_valid <= 1'b1;
            end
          end
          if (&drive) begin
            // Last vector: drive keeps holding all ones after the run.
            state_q <= StDone;
          end else begin
            drive   <= drive + N_IN'(1);
            cnt_q   <= CntMax;
            state_q <= StSettle;
          end
        end

        StDone: begin
          // err_count already includes the final sample, updated on the previous edge.
          done    <= 1'b1;
          busy    <= 1'b0;
          pass    <= (func_q != FuncRsvd) && (err_count == '0);
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gate_sequencer.sv
module tb_logic_gate_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func = 3'd0;
  logic       sample_in;
  logic [1:0] drive;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [1:0] fail_vec;

  // Second instance: three inputs with a two-bit counter, used for the saturation scenario.
  logic       start3 = 1'b0;
  logic [2:0] func3 = 3'd1;
  logic       sample3;
  logic [2:0] drive3;
  logic       busy3, done3, pass3, fail_valid3;
  logic [1:0] err_count3;
  logic [2:0] fail_vec3;

  int total = 0;
  int bad = 0;

  // Gate model in front of the main instance: 0 ideal, 1 stuck at 0, 2 inverted output.
  int         mode = 0;
  logic [2:0] model_func = 3'd0;
  logic       ideal;

  always #5 clk = ~clk;

  always_comb begin
    ideal = 1'b0;
    case (model_func)
      3'd0: ideal = drive[0] & drive[1];
      3'd1: ideal = ~(drive[0] & drive[1]);
      3'd2: ideal = drive[0] | drive[1];
      3'd3: ideal = ~(drive[0] | drive[1]);
      3'd4: ideal = drive[0] ^ drive[1];
      3'd5: ideal = ~(drive[0] ^ drive[1]);
      3'd6: ideal = ~drive[0];
      default: ideal = 1'b0;
    endcase
    sample_in = (mode == 0) ? ideal : (mode == 1) ? 1'b0 : ~ideal;
  end

  // Every sample wrong for NAND: present AND instead.
  assign sample3 = &drive3;

  logic_gate_sequencer #(.N_IN(2), .SETTLE(4), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .func       (func),
    .sample_in  (sample_in),
    .drive      (drive),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .fail_valid (fail_valid)
  );

  logic_gate_sequencer #(.N_IN(3), .SETTLE(4), .CNT_W(2)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start3),
    .func       (func3),
    .sample_in  (sample3),
    .drive      (drive3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err_count3),
    .fail_vec   (fail_vec3),
    .fail_valid (fail_valid3)
  );

  // Starts a run on the main instance and returns the number of edges from the accept
  // edge to the one that raises done (-1 on timeout). chk_seq checks the drive sweep and
  // busy every cycle; poke re-asserts start and changes func while the run is active.
  task automatic run_main(input bit chk_seq, input bit poke, output int k_done);
    int e;
    k_done = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (err_count !== 8'd0 || fail_valid !== 1'b0 || pass !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_clear: err=%0d fv=%b pass=%b busy=%b want 0 0 0 1",
               err_count, fail_valid, pass, busy);
    end
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        k_done = k;
        break;
      end
      if (chk_seq) begin
        e = (k / 5 > 3) ? 3 : k / 5;
        total++;
        if (drive !== 2'(e) || busy !== 1'b1) begin
          bad++;
          $display("FAIL sweep k=%0d: drive=%b busy=%b want drive=%b busy=1", k, drive, busy,
                   2'(e));
        end
      end
      if (poke) begin
        start = (k == 3 || k == 12 || k == 20);
        func  = (k >= 5 && k < 15) ? 3'd7 : 3'd0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (drive !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        err_count !== 8'd0 || fail_vec !== 2'b00 || fail_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: drive=%b busy=%b done=%b pass=%b err=%0d fvec=%b fv=%b want all 0",
               drive, busy, done, pass, err_count, fail_vec, fail_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_and();
    int k;
    mode = 0; model_func = 3'd0; func = 3'd0;
    run_main(1'b1, 1'b0, k);
    total++;
    if (k !== 21) begin bad++; $display("FAIL and_latency: got %0d want 21", k); end
    total++;
    if (pass !== 1'b1 || err_count !== 8'd0 || fail_valid !== 1'b0 || busy !== 1'b0 ||
        drive !== 2'b11) begin
      bad++;
      $display("FAIL and_result: pass=%b err=%0d fv=%b busy=%b drive=%b want 1 0 0 0 11",
               pass, err_count, fail_valid, busy, drive);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || pass !== 1'b1 || drive !== 2'b11) begin
      bad++;
      $display("FAIL and_hold: done=%b pass=%b drive=%b want 0 1 11", done, pass, drive);
    end
  endtask

  task automatic test_or_stuck();
    int k;
    mode = 1; model_func = 3'd2; func = 3'd2;
    run_main(1'b0, 1'b0, k);
    total++;
    if (k !== 21 || err_count !== 8'd3 || fail_vec !== 2'b01 || fail_valid !== 1'b1 ||
        pass !== 1'b0) begin
      bad++;
      $display("FAIL or_stuck: k=%0d err=%0d fvec=%b fv=%b pass=%b want 21 3 01 1 0",
               k, err_count, fail_vec, fail_valid, pass);
    end
  endtask

  task automatic test_xnor_inverted();
    int k;
    mode = 2; model_func = 3'd5; func = 3'd5;
    run_main(1'b0, 1'b0, k);
    total++;
    if (k !== 21 || err_count !== 8'd4 || fail_vec !== 2'b00 || fail_valid !== 1'b1 ||
        pass !== 1'b0) begin
      bad++;
      $display("FAIL xnor_inv: k=%0d err=%0d fvec=%b fv=%b pass=%b want 21 4 00 1 0",
               k, err_count, fail_vec, fail_valid, pass);
    end
    // Same inverted gate checked as XOR matches XNOR's inverse: clean run.
    func = 3'd4;
    run_main(1'b0, 1'b0, k);
    total++;
    if (k !== 21 || err_count !== 8'd0 || fail_valid !== 1'b0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL xor_inv: k=%0d err=%0d fv=%b pass=%b want 21 0 0 1",
               k, err_count, fail_valid, pass);
    end
  endtask

  task automatic test_reset_midrun();
    int k;
    bit seen;
    mode = 0; model_func = 3'd0; func = 3'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    total++;
    if (drive !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort: drive=%b busy=%b want 01 1", drive, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (drive !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort: drive=%b busy=%b done=%b want 00 0 0", drive, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL abort_quiet: got done/busy activity want none"); end
    run_main(1'b0, 1'b0, k);
    total++;
    if (k !== 21 || pass !== 1'b1) begin
      bad++;
      $display("FAIL after_abort: k=%0d pass=%b want 21 1", k, pass);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    mode = 0; model_func = 3'd0; func = 3'd0;
    run_main(1'b1, 1'b1, k);
    func = 3'd0;
    total++;
    if (k !== 21 || pass !== 1'b1 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL poke_run: k=%0d pass=%b err=%0d want 21 1 0", k, pass, err_count);
    end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL no_queue: got restart want idle"); end
    // Reserved function: immediate done, pass forced low.
    @(negedge clk);
    func = 3'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_accept: busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 8'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_done: done=%b pass=%b err=%0d busy=%b want 1 0 0 0",
               done, pass, err_count, busy);
    end
    func = 3'd0;
  endtask

  task automatic test_saturate();
    int kd;
    kd = -1;
    @(negedge clk);
    func3 = 3'd1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done3 === 1'b1) begin
        kd = k;
        break;
      end
    end
    total++;
    if (kd !== 41) begin bad++; $display("FAIL sat_latency: got %0d want 41", kd); end
    total++;
    if (err_count3 !== 2'd3 || fail_vec3 !== 3'b000 || fail_valid3 !== 1'b1 ||
        pass3 !== 1'b0 || drive3 !== 3'b111) begin
      bad++;
      $display("FAIL sat_result: err=%0d fvec=%b fv=%b pass=%b drive=%b want 3 000 1 0 111",
               err_count3, fail_vec3, fail_valid3, pass3, drive3);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_stuck();
    test_xnor_inverted();
    test_reset_midrun();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_sequencer.md
Name: logic_gate_sequencer

Overview:
Self-checking stimulus controller for the two-input and one-input logic primitives in the digital device library: AND, NAND, OR, NOR, XOR, XNOR and INV.
- Drives every input combination onto a device-under-test gate.
- Waits a programmable settle time that covers the gate's delay and rise/fall.
- Samples the thresholded output and compares it against the expected truth table.
- Reports the mismatch count and the first failing vector.

It sits between the bench harness and the analog-modelled gate instances, and is used for regression of the logic-device mapping.

Parameters:
N_IN, 2, number of gate inputs driven (1..4)
SETTLE, 4, clock cycles to wait after applying a vector before sampling (>=1)
CNT_W, 8, width of the error counter

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; accepted only in IDLE
func  in  3  gate under test: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 INV, 7 reserved
sample_in  in  1  DUT output after thresholding (1 = above thh, 0 = below thl)
drive  out  N_IN  stimulus vector applied to DUT inputs (bit 0 = input a)
busy  out  1  high from start acceptance until the cycle before done
done  out  1  single-cycle pulse at end of run
pass  out  1  1 when the last run had zero mismatches
err_count  out  CNT_W  mismatches in the last or current run, saturating
fail_vec  out  N_IN  first vector that mismatched
fail_valid  out  1  fail_vec holds a captured vector

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst_n low asynchronously forces state IDLE and all outputs to 0: drive, busy, done, pass, err_count, fail_vec and fail_valid.
  - Reset mid-run aborts the run. No done is produced.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1, func!=7:
  - Latch func.
  - Set vec=0, drive=0.
  - Clear err_count, pass, fail_valid and fail_vec.
  - Load settle counter = SETTLE-1.
  - busy=1, go to SETTLE.
- IDLE, start=1, func=7:
  - Clear err_count and fail_valid, set pass=0.
  - Go to DONE. busy stays 0.
- SETTLE:
  - drive holds vec.
  - Counter decrements each cycle; at 0, go to SAMPLE.
  - Dwell is exactly SETTLE cycles.
- SAMPLE, one cycle. Compare sample_in with expected(func, vec):
  - AND: all N_IN bits are 1. NAND: its inverse.
  - OR: any bit is 1. NOR: its inverse.
  - XOR: parity of vec. XNOR: its inverse.
  - INV: ~vec[0]; upper bits are still swept, and the expected value ignores them.
- On mismatch in SAMPLE:
  - err_count increments, saturating at all ones.
  - If fail_valid=0, capture fail_vec=vec and set fail_valid=1.
- SAMPLE exit:
  - If vec is all ones, go to DONE.
  - Otherwise vec+1, drive updates on the same edge, reload the counter, go to SETTLE.
- DONE, one cycle:
  - done=1, busy=0.
  - pass=(err_count==0), including the final sample's result. func=7 forces pass=0.
  - Go to IDLE.
- Latency: from the start-accept edge to the done pulse is 2^N_IN*(SETTLE+1)+1 cycles.
- start handling:
  - start outside IDLE is ignored, with no queuing.
  - start in the DONE cycle is ignored.
  - func changes during a run have no effect.
- Holding: err_count, pass, fail_vec, fail_valid and drive hold after done until the next accepted start. drive holds the all-ones vector.

Test Plan:
1. N_IN=2, SETTLE=4, func=0, ideal AND model -> drive sequence 00,01,10,11, each held 5 cycles; done 21 cycles after start; pass=1, err_count=0, fail_valid=0.
2. func=2 (OR), sample_in stuck at 0 -> err_count=3, fail_vec=01, fail_valid=1, pass=0.
3. func=5 (XNOR), DUT output inverted -> err_count=4, fail_vec=00, pass=0; then func=4 with the same DUT -> pass=1, and counters are cleared at start.
4. rst_n pulsed low 7 cycles into a run -> drive=0, busy=0 immediately with no done; next start runs the full 21 cycles.
5. start reasserted while busy -> ignored, the run completes unchanged; func=7 in IDLE -> done on the next cycle with pass=0, err_count=0.
6. N_IN=3, CNT_W=2, func=1, every sample wrong -> 8 mismatches, err_count saturates at 3, fail_vec=000, done after 8*(SETTLE+1)+1 cycles.
